// File: rtl/adder_issue_ctrl.sv
// adder_issue_ctrl
// Issue/capture sequencer for a completion-detecting 32-bit adder.
// It takes an operand pair over an input valid/ready handshake and holds it
// on the adder inputs. It pulses the adder first-signal F, then waits for the
// adder's asynchronous ready R through a synchronizer, bounded by a timeout.
// The captured sum/carry and the measured wait latency are offered downstream
// over an output valid/ready handshake.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operand handshake
//   in_a, in_b, in_cin          operands and carry-in
//   add_a, add_b, add_cin       registered operands driven to the adder
//   add_f                       one-cycle first pulse (restarts adder timing)
//   add_request                 operation in flight
//   add_ready                   asynchronous adder completion R
//   add_sum, add_cout           adder result, trusted only at capture
//   out_valid/out_ready         result handshake
//   out_sum, out_cout           captured result
//   out_timeout                 result captured by timeout rather than R
//   out_cycles                  WAIT cycles elapsed at capture
module adder_issue_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WAIT    = 3,
  parameter int MAX_WAIT    = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  output logic             add_f,
  output logic             add_request,
  input  logic             add_ready,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_timeout,
  output logic [5:0]       out_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_ready_s;
  logic [5:0]             cnt_r;
  logic [5:0]             cnt_inc_s;
  logic                   done_s;
  logic                   timeout_s;
  logic                   accept_s;
  logic                   capture_s;

  logic                   in_ready_r;
  logic                   out_valid_r;
  logic                   add_f_r;
  logic                   add_request_r;
  logic [WIDTH-1:0]       add_a_r;
  logic [WIDTH-1:0]       add_b_r;
  logic                   add_cin_r;
  logic [WIDTH-1:0]       out_sum_r;
  logic                   out_cout_r;
  logic                   out_timeout_r;
  logic [5:0]             out_cycles_r;

  assign sync_ready_s = sync_r[SYNC_STAGES-1];
  assign cnt_inc_s    = cnt_r + 6'd1;
  // Samples earlier than MIN_WAIT may still carry R from the previous operation.
  assign done_s       = sync_ready_s && (cnt_inc_s >= 6'(MIN_WAIT));
  assign timeout_s    = (cnt_inc_s == 6'(MAX_WAIT));

  // Next-state logic and the single-cycle accept/capture strobes.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          state_s  = ST_LAUNCH;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_s || timeout_s) begin
          state_s   = ST_HOLD;
          capture_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus control outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      add_f_r       <= 1'b0;
      add_request_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      in_ready_r    <= (state_s == ST_IDLE);
      out_valid_r   <= (state_s == ST_HOLD);
      add_f_r       <= (state_s == ST_LAUNCH);
      add_request_r <= (state_s == ST_LAUNCH) || (state_s == ST_WAIT);
    end
  end

  // Synchronizer for the asynchronous adder ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], add_ready};
    end
  end

  // WAIT-cycle counter, cleared during the launch cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 6'd0;
    end else if (state_r == ST_LAUNCH) begin
      cnt_r <= 6'd0;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_inc_s;
    end
  end

  // Operand registers, loaded only on an accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_r   <= '0;
      add_b_r   <= '0;
      add_cin_r <= 1'b0;
    end else if (accept_s) begin
      add_a_r   <= in_a;
      add_b_r   <= in_b;
      add_cin_r <= in_cin;
    end
  end

  // Result registers; completion takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_r     <= '0;
      out_cout_r    <= 1'b0;
      out_timeout_r <= 1'b0;
      out_cycles_r  <= 6'd0;
    end else if (capture_s) begin
      out_sum_r     <= add_sum;
      out_cout_r    <= add_cout;
      out_timeout_r <= !done_s;
      out_cycles_r  <= cnt_inc_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign add_f       = add_f_r;
  assign add_request = add_request_r;
  assign add_a       = add_a_r;
  assign add_b       = add_b_r;
  assign add_cin     = add_cin_r;
  assign out_sum     = out_sum_r;
  assign out_cout    = out_cout_r;
  assign out_timeout = out_timeout_r;
  assign out_cycles  = out_cycles_r;

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Testbench for adder_issue_ctrl: scoreboard queue filled at accept time,
// monitor pops and compares at each output handshake. The adder is modelled
// behaviourally: R drops when F is seen and rises a chosen number of cycles
// later (delay 0 means R tied high).
module tb_adder_issue_ctrl;
  localparam int W        = 32;
  localparam int MIN_WAIT = 3;
  localparam int MAX_WAIT = 34;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic [W-1:0] add_a, add_b;
  logic         add_cin, add_f, add_request;
  logic         add_ready = 1'b0;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout, out_timeout;
  logic [5:0]   out_cycles;
  logic [W:0]   full_s;

  adder_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_f(add_f), .add_request(add_request), .add_ready(add_ready),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_timeout(out_timeout), .out_cycles(out_cycles)
  );

  always #5 clk = ~clk;

  // Behavioural adder: result is always the true sum of the held operands.
  assign full_s   = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum  = full_s[W-1:0];
  assign add_cout = full_s[W];

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         tmo;
    int           cycles;
    int           acc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int cur_delay = 0;
  int dcnt = 0;
  logic prev_ov = 1'b0;
  logic rand_bp = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Adder completion model.
  always @(negedge clk) begin
    if (cur_delay == 0) begin
      add_ready = 1'b1;
    end else if (add_f) begin
      add_ready = 1'b0;
      dcnt = cur_delay;
    end else if (dcnt > 0) begin
      dcnt = dcnt - 1;
      if (dcnt == 0) add_ready = 1'b1;
    end
  end

  // Random downstream backpressure, changed away from the sampling edge.
  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 9) < 7);
  end

  // Monitor: F timing, output latency, and result comparison at handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (add_f) begin
        if (q.size() == 0) chk("f_unexpected", 64'd1, 64'd0);
        else chk("f_timing", 64'(cyc), 64'(q[0].acc));
      end
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("valid_unexpected", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - q[0].acc), 64'(q[0].cycles + 1));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("xfer_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", 64'(out_sum), 64'(e.sum));
          chk("cout", 64'(out_cout), 64'(e.cout));
          chk("timeout", 64'(out_timeout), 64'(e.tmo));
          chk("cycles", 64'(out_cycles), 64'(e.cycles));
        end
        hs_cnt++;
      end
      prev_ov = out_valid;
    end
  end

  // Offer one operand pair; d selects the modelled adder delay (0 = R tied high).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input int d);
    exp_t e;
    logic [W:0] full;
    int c;
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_wait", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      cur_delay = d;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      c = (d == 0) ? MIN_WAIT : d + 2;
      if (c < MIN_WAIT) c = MIN_WAIT;
      e.tmo = (c > MAX_WAIT);
      if (c > MAX_WAIT) c = MAX_WAIT;
      e.sum = full[W-1:0];
      e.cout = full[W];
      e.cycles = c;
      e.acc = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      in_a = $urandom();
      in_b = $urandom();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] bp_sum;
    logic [W-1:0] ta, tb;
    logic         tc;
    int           hs0;
    int           nvalid;
    int           r;
    int           d;
    int           n;

    // Reset with random inputs applied.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom());
      in_a = $urandom();
      in_b = $urandom();
      in_cin = 1'($urandom());
      out_ready = 1'($urandom());
    end
    chk("rst_ctrl", 64'({in_ready, out_valid, add_f, add_request, add_cin,
                         out_cout, out_timeout, out_cycles}), 64'd0);
    chk("rst_ops", {add_a, add_b}, 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("rdy_after_edge", 64'(in_ready), 64'd1);

    // Basic add, R tied high.
    issue(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
    wait_drain();

    // Long carry with R low for 10 cycles.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 10);
    wait_drain();

    // Timeout, coincident completion, and one cycle too late.
    issue($urandom(), $urandom(), 1'b1, 1000);
    wait_drain();
    issue($urandom(), $urandom(), 1'b0, MAX_WAIT - 2);
    wait_drain();
    issue($urandom(), $urandom(), 1'b1, MAX_WAIT - 1);
    wait_drain();

    // Backpressure: hold the result 20 cycles while in_valid is asserted.
    @(posedge clk);
    #1 out_ready = 1'b0;
    ta = $urandom();
    tb = $urandom();
    tc = 1'($urandom());
    bp_sum = ta + tb + {{(W-1){1'b0}}, tc};
    issue(ta, tb, tc, 5);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 64'(out_valid), 64'd1);
    hs0 = hs_cnt;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_a = $urandom();
      in_b = $urandom();
      @(negedge clk);
      chk("bp_stable", 64'(out_sum), 64'(bp_sum));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    repeat (5) @(negedge clk);
    chk("bp_one_xfer", 64'(hs_cnt - hs0), 64'd1);

    // Reset mid-WAIT at cnt=5.
    issue($urandom(), $urandom(), 1'b0, 20);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_request", 64'(add_request), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("mid_rst_no_valid", 64'(nvalid), 64'd0);
    issue($urandom(), $urandom(), 1'($urandom()), $urandom_range(0, 6));
    wait_drain();

    // Randomized traffic with random backpressure.
    @(posedge clk);
    #2 rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: d = 0;
        1: d = MAX_WAIT - 2;
        2: d = MAX_WAIT - 1;
        3: d = 40;
        default: d = $urandom_range(1, 12);
      endcase
      issue($urandom(), $urandom(), 1'($urandom()), d);
    end
    @(posedge clk);
    #2 rand_bp = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_issue_ctrl.md
# adder_issue_ctrl

Upstream issue/capture sequencer for the 32-bit dynamic (completion-detecting) adder. It accepts operand pairs over a valid/ready handshake and holds them stable on the adder inputs. It pulses the adder's first-signal `F`, then waits for the adder's asynchronous ready `R` through a synchronizer, with a worst-case timeout. The captured sum/carry and measured latency are presented downstream over a second valid/ready handshake.

## Interface
- `WIDTH`, 32, operand/sum width
- `SYNC_STAGES`, 2, flops in the `add_ready` synchronizer
- `MIN_WAIT`, 3, minimum WAIT cycles before a synchronized ready is trusted; must be at least SYNC_STAGES+1
- `MAX_WAIT`, 34, WAIT cycles after which the result is captured unconditionally
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  block can accept operands
- `in_a`, `in_b`  in  WIDTH  operands
- `in_cin`  in  1  carry-in
- `add_a`, `add_b`  out  WIDTH  registered operands to the adder
- `add_cin`  out  1  registered carry-in to the adder
- `add_f`  out  1  one-cycle first pulse; restarts adder timing
- `add_request`  out  1  operation in flight
- `add_ready`  in  1  adder completion `R`, asynchronous to `clk`
- `add_sum`  in  WIDTH  adder sum, valid when `add_ready` is high
- `add_cout`  in  1  adder carry-out
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts result
- `out_sum`  out  WIDTH  captured sum
- `out_cout`  out  1  captured carry-out
- `out_timeout`  out  1  result was captured by timeout, not by ready
- `out_cycles`  out  6  WAIT cycles elapsed at capture, 1..MAX_WAIT

## Operation
- FSM states: IDLE, LAUNCH, WAIT, HOLD. Reset state is IDLE.
- IDLE
  - `in_ready`=1.
  - On `in_valid & in_ready`: register `in_a`/`in_b`/`in_cin` into `add_a`/`add_b`/`add_cin`, clear `in_ready`, go to LAUNCH.
  - `in_valid` while `in_ready`=0 is ignored. Data is not sampled.
- LAUNCH (exactly one cycle)
  - `add_f`=1, `add_request`=1, wait counter cleared to 0.
  - Go to WAIT.
- WAIT
  - `add_request`=1, `add_f`=0.
  - Each edge: cnt_next = cnt+1.
  - Completion is `sync_ready & cnt_next>=MIN_WAIT`. On completion: capture `add_sum`/`add_cout` into `out_sum`/`out_cout`, set `out_timeout`=0 and `out_cycles`=cnt_next, go to HOLD.
  - Otherwise, if cnt_next==MAX_WAIT: capture the same signals, set `out_timeout`=1, go to HOLD.
  - If completion and timeout occur on the same edge, completion wins (`out_timeout`=0).
  - `sync_ready` samples before MIN_WAIT are discarded. This masks stale `R` left over from the previous operation.
- HOLD
  - `out_valid`=1, `add_request`=0. Outputs are held stable while `out_ready`=0.
  - On `out_valid & out_ready`: clear `out_valid`, set `in_ready`, go to IDLE.
- `add_a`/`add_b`/`add_cin` change only on an accept edge. They stay stable through LAUNCH, WAIT and HOLD.
- Synchronizer: SYNC_STAGES flops on `add_ready`, reset to 0. No other signal crosses domains. `add_sum` is sampled only on the completion edge.

## Timing
- Reset (asynchronous assert): all outputs and registers are 0, FSM is IDLE, `in_ready`=0.
- `in_ready` becomes 1 at the first rising edge after `rst_n` deasserts.
- `in_ready`, `out_valid`, `add_f`, `add_request` and all data outputs are registered. There are no combinational paths from input to output.
- Let E0 be the accept edge:
  - `add_f` is high between E0 and E1.
  - WAIT starts at E1.
  - Earliest capture is at E1+MIN_WAIT, i.e. E4 at defaults; `out_valid` rises there.
  - Timeout capture is at E1+MAX_WAIT, i.e. E35, with `out_cycles`=34.
- With `out_ready` tied high, HOLD lasts one cycle. `in_ready` rises on the handshake edge, so the next accept can occur one edge later. Minimum issue period is 6 cycles at defaults.
- Reset asserted mid-operation (any state): immediate return to reset values. `add_request` and `out_valid` drop asynchronously. The in-flight result is discarded.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> all outputs 0. After release, `in_ready`=1 after exactly one edge.
- Basic add with `add_ready` tied high: A=0x0000_0005, B=0x0000_0003, cin=0 -> `add_f` pulses for one cycle. `out_valid` rises 4 edges after accept, with `out_sum`=0x8, `out_cout`=0, `out_timeout`=0, `out_cycles`=3.
- Long carry: A=0xFFFF_FFFF, B=1, cin=0, with a model holding `R` low for 10 cycles after `F` -> `out_sum`=0, `out_cout`=1, `out_cycles`=12 (10 cycles plus 2-flop sync), `out_timeout`=0.
- Timeout: `add_ready` stuck low -> capture after 34 WAIT cycles, `out_timeout`=1, `out_cycles`=34. `add_ready` rising on that same edge -> `out_timeout`=0.
- Backpressure: `out_ready`=0 for 20 cycles, then 1 -> `out_sum` stable throughout, `in_valid` ignored during that time, exactly one transfer, `in_ready` rises on the handshake edge.
- Reset mid-WAIT (pulse `rst_n` low at cnt=5) -> `add_request`=0 immediately, no `out_valid`. The next operation completes normally with `out_cycles`≥3.
